// File: rtl/fwd_pkg.sv
// fwd_pkg: shared widths, state encoding, beat record and final-beat keep helper
// for the packet forwarder.
package fwd_pkg;
  localparam int FWD_DATA_WIDTH = 64;
  localparam int FWD_KEEP_WIDTH = 8;
  localparam int FWD_LEN_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} fwd_state_e;
  typedef struct packed {
    logic [FWD_DATA_WIDTH-1:0] data;
    logic [FWD_KEEP_WIDTH-1:0] keep;
    logic                      last;
  } fwd_beat_t;
  // Byte 0 sits in the top lane, so a partial final beat keeps the top rem lanes.
  function automatic logic [FWD_KEEP_WIDTH-1:0] fwd_last_keep(input logic [2:0] rem);
    return rem == 3'd0 ? '1 : ~({FWD_KEEP_WIDTH{1'b1}} >> rem);
  endfunction
endpackage

// File: rtl/fwd_skid_buffer.sv
// fwd_skid_buffer: 2-entry beat FIFO between packet-memory reads and the AXI-Stream
// master; in_ready flags that at least one entry is free.
module fwd_skid_buffer
  import fwd_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      in_valid,
  output logic      in_ready,
  input  fwd_beat_t in_beat,
  output logic      out_valid,
  input  logic      out_ready,
  output fwd_beat_t out_beat,
  output logic      empty
);
  fwd_beat_t mem_q [2];
  fwd_beat_t mem_d [2];
  logic wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic push, pop;
  assign in_ready = cnt_q != 2'd2;
  assign out_valid = cnt_q != 2'd0;
  assign empty = !out_valid;
  assign out_beat = out_valid ? mem_q[rd_ptr_q] : '0;
  always_comb begin
    push = in_valid && in_ready;
    pop = out_valid && out_ready;
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = in_beat;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mem_q <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/packet_forwarder.sv
// packet_forwarder: streams a filled packet buffer out over AXI-Stream, then pulses
// forwarder_done to release it. FWD_PKT_COUNT_EN adds a 32-bit forwarded-packet counter.
module packet_forwarder
  import fwd_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ready_for_forwarder,
  input  logic [FWD_LEN_WIDTH-1:0]  len_to_forwarder,
  output logic [ADDR_WIDTH-1:0]     forwarder_rd_addr,
  output logic                      forwarder_rd_en,
  input  logic [FWD_DATA_WIDTH-1:0] forwarder_rd_data,
  output logic                      forwarder_done,
  output logic [FWD_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [FWD_KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready
`ifdef FWD_PKT_COUNT_EN
  ,
  output logic [31:0]               pkt_count
`endif
);
  localparam int RAW_W = FWD_LEN_WIDTH - 2;
  localparam logic [RAW_W-1:0] MAX_BEATS = RAW_W'(1) << (ADDR_WIDTH - 1);
  fwd_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] beats_q, beats_d, addr_q, addr_d;
  logic [FWD_KEEP_WIDTH-1:0] keep_q, keep_d, fl_keep_q, fl_keep_d;
  logic fl_q, fl_d, fl_last_q, fl_last_d, done_q, done_d;
  logic [RAW_W-1:0] raw_beats;
  logic last_rd, pop, slot_free, sk_ready, sk_empty;
  fwd_beat_t sk_out;
  fwd_skid_buffer u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (fl_q),
    .in_ready (sk_ready),
    .in_beat  ('{data: forwarder_rd_data, keep: fl_keep_q, last: fl_last_q}),
    .out_valid(m_axis_tvalid),
    .out_ready(m_axis_tready),
    .out_beat (sk_out),
    .empty    (sk_empty)
  );
  assign m_axis_tdata = sk_out.data;
  assign m_axis_tkeep = sk_out.keep;
  assign m_axis_tlast = sk_out.last;
  assign forwarder_rd_addr = addr_q;
  assign forwarder_done = done_q;
  // A read may issue only if its beat will find a slot once it lands, counting
  // the beat already in flight and any beat leaving this cycle.
  assign pop = m_axis_tvalid && m_axis_tready;
  assign slot_free = pop || sk_empty || (sk_ready && !fl_q);
  assign last_rd = addr_q == beats_q - 1'b1;
  always_comb begin
    state_d = state_q;
    beats_d = beats_q;
    keep_d = keep_q;
    addr_d = addr_q;
    forwarder_rd_en = 1'b0;
    raw_beats = {1'b0, len_to_forwarder[FWD_LEN_WIDTH-1:3]} + RAW_W'(|len_to_forwarder[2:0]);
    case (state_q)
      IDLE: if (ready_for_forwarder) begin
        beats_d = raw_beats > MAX_BEATS ? MAX_BEATS[ADDR_WIDTH-1:0] : raw_beats[ADDR_WIDTH-1:0];
        keep_d = fwd_last_keep(len_to_forwarder[2:0]);
        addr_d = '0;
        state_d = len_to_forwarder == '0 ? DONE : READ;
      end
      READ: begin
        forwarder_rd_en = slot_free;
        if (slot_free) begin
          addr_d = last_rd ? '0 : addr_q + 1'b1;
          state_d = last_rd ? DRAIN : READ;
        end
      end
      DRAIN: state_d = sk_empty && !fl_q ? DONE : DRAIN;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    fl_d = forwarder_rd_en;
    fl_keep_d = last_rd ? keep_q : '1;
    fl_last_d = last_rd;
    done_d = state_q == DONE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      beats_q <= '0;
      keep_q <= '0;
      addr_q <= '0;
      fl_q <= 1'b0;
      fl_keep_q <= '0;
      fl_last_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
      keep_q <= keep_d;
      addr_q <= addr_d;
      fl_q <= fl_d;
      fl_keep_q <= fl_keep_d;
      fl_last_q <= fl_last_d;
      done_q <= done_d;
    end
`ifdef FWD_PKT_COUNT_EN
  logic [31:0] pkt_count_q, pkt_count_d;
  always_comb pkt_count_d = pkt_count_q + {31'b0, done_q};
  always_ff @(posedge clk or negedge rst)
    if (!rst) pkt_count_q <= '0;
    else pkt_count_q <= pkt_count_d;
  assign pkt_count = pkt_count_q;
`endif
endmodule

// File: tb/tb_packet_forwarder.sv
// tb_packet_forwarder: directed tests for packet_forwarder against a beat-queue model
// of the packet, plus literal expectations; honours FWD_PKT_COUNT_EN.
module tb_packet_forwarder;
  localparam int AW = 10;
  typedef struct packed {logic [63:0] data; logic [7:0] keep; logic last;} exp_beat_t;
  logic clk = 0, rst = 0, ready = 0, tready = 0;
  logic [31:0] len = 0;
  logic [AW-1:0] rd_addr;
  logic rd_en, done, tlast, tvalid;
  logic [63:0] rd_data = 0, tdata;
  logic [7:0] tkeep;
`ifdef FWD_PKT_COUNT_EN
  logic [31:0] pkt_count;
`endif
  packet_forwarder #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .ready_for_forwarder(ready), .len_to_forwarder(len),
    .forwarder_rd_addr(rd_addr), .forwarder_rd_en(rd_en), .forwarder_rd_data(rd_data),
    .forwarder_done(done), .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tlast(tlast),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready)
`ifdef FWD_PKT_COUNT_EN
    , .pkt_count(pkt_count)
`endif
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [63:0] seed = 64'h0123_4567_89AB_CDEF;
  function automatic logic [63:0] word(input logic [63:0] s, input int a);
    return s ^ (64'(a) * 64'h9E37_79B9_7F4A_7C15);
  endfunction
  function automatic logic [7:0] keep_for(input int l);
    int r = l % 8;
    logic [7:0] k = 8'hFF;
    return r == 0 ? k : k << (8 - r);
  endfunction
  always @(posedge clk) if (rd_en) rd_data <= word(seed, int'(rd_addr));
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask
  // Model: an accepted packet becomes a queue of expected beats; the DUT is idle
  // until reset or from the cycle its done pulse appears.
  exp_beat_t exp_q[$];
  bit busy = 0, stall_prev = 0;
  int nb = 0, issued = 0, popped = 0, done_cnt = 0, beat_cnt = 0, done_cyc = -1;
  int first_tv = -1, last_beat = -1;
  logic [63:0] prev_data = 0;
  logic [7:0] keep_log[$];
  logic last_log[$];
  logic [AW-1:0] addr_log[$];
  always @(negedge clk) begin
    if (!rst) begin
      chk("reset_ctl", 64'({rd_en, done, tvalid, tlast, tkeep, rd_addr}), 64'd0);
      chk("reset_tdata", tdata, 64'd0);
      exp_q.delete();
      busy = 0;
      stall_prev = 0;
    end else begin
      if (stall_prev) chk("tvalid_held", 64'(tvalid), 64'd1);
      if (stall_prev) chk("tdata_stable", tdata, prev_data);
      if (tvalid) begin
        if (first_tv < 0) first_tv = cyc;
        chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          chk("tdata", tdata, exp_q[0].data);
          chk("tkeep_tlast", 64'({tkeep, tlast}), 64'({exp_q[0].keep, exp_q[0].last}));
          if (tready) begin
            void'(exp_q.pop_front());
            popped++;
            beat_cnt++;
            last_beat = cyc;
            keep_log.push_back(tkeep);
            last_log.push_back(tlast);
          end
        end
      end
      stall_prev = tvalid && !tready;
      prev_data = tdata;
      if (rd_en) begin
        chk("rd_addr", 64'(rd_addr), 64'(issued));
        chk("rd_window", 64'(busy && issued < nb && issued - popped < 2), 64'd1);
        addr_log.push_back(rd_addr);
        issued++;
      end
      if (done) begin
        chk("done_expected", 64'({busy, exp_q.size() == 0, issued == nb}), 64'b111);
        done_cnt++;
        done_cyc = cyc;
        busy = 0;
      end
      if (!busy && ready) begin
        busy = 1;
        nb = int'((longint'(len) + 7) / 8);
        if (nb > 2 ** (AW - 1)) nb = 2 ** (AW - 1);
        issued = 0;
        popped = 0;
        for (int i = 0; i < nb; i++)
          exp_q.push_back('{word(seed, i), i == nb - 1 ? keep_for(int'(len)) : 8'hFF, i == nb - 1});
      end
    end
  end
  task automatic send(input int l);
    len = 32'(l);
    ready = 1;
    @(posedge clk);
    #1 ready = 0;
  endtask
  task automatic wait_done(input int n, input int budget);
    for (int c = 0; c < budget && done_cnt < n; c++) @(posedge clk);
    #1 chk("done_reached", 64'(done_cnt >= n), 64'd1);
  endtask
  task automatic clear_logs();
    keep_log.delete();
    last_log.delete();
    addr_log.delete();
    beat_cnt = 0;
    first_tv = -1;
    last_beat = -1;
  endtask
  bit toggle = 0;
  int start, base;
  initial begin
    repeat (3) @(posedge clk);
    #1 chk("reset_outs", 64'({rd_en, done, tvalid, tlast, tkeep, rd_addr}), 64'd0);
`ifdef FWD_PKT_COUNT_EN
    chk("reset_pkt_count", 64'(pkt_count), 64'd0);
`endif
    rst = 1;
    // len=20: three beats, partial last beat
    tready = 1;
    clear_logs();
    start = cyc;
    send(20);
    wait_done(1, 50);
    chk("t20_beats", 64'(beat_cnt), 64'd3);
    chk("t20_keeps", 64'({keep_log[0], keep_log[1], keep_log[2]}), 64'hFFFFF0);
    chk("t20_lasts", 64'({last_log[0], last_log[1], last_log[2]}), 64'b001);
    chk("t20_addrs", 64'({addr_log[0], addr_log[1], addr_log[2]}), 64'({10'd0, 10'd1, 10'd2}));
    chk("t20_latency", 64'(first_tv - start), 64'd3);
    chk("t20_rate", 64'(last_beat - first_tv), 64'd2);
    repeat (4) @(posedge clk);
    #1 chk("t20_one_done", 64'(done_cnt), 64'd1);
    // len=0: no stream, done two cycles after request
    clear_logs();
    start = cyc;
    send(0);
    wait_done(2, 20);
    chk("t0_done_latency", 64'(done_cyc - start), 64'd2);
    chk("t0_no_beats", 64'(first_tv), 64'hFFFF_FFFF_FFFF_FFFF);
    // len=64 with tready toggling each cycle
    seed = 64'hDEAD_BEEF_CAFE_F00D;
    clear_logs();
    toggle = 1;
    fork
      while (toggle) begin
        @(posedge clk);
        #1 tready = ~tready;
      end
    join_none
    send(64);
    wait_done(3, 80);
    toggle = 0;
    repeat (2) @(posedge clk);
    #1 tready = 1;
    chk("t64_beats", 64'(beat_cnt), 64'd8);
    chk("t64_final", 64'({keep_log[7], last_log[7]}), 64'h1FF);
    // back-to-back: len 8 then 9 with ready held high
    seed = 64'h1111_2222_3333_4444;
    clear_logs();
    base = done_cnt;
    len = 8;
    ready = 1;
    for (int c = 0; c < 40 && beat_cnt < 1; c++) begin
      @(posedge clk);
      #1;
    end
    len = 9;
    for (int c = 0; c < 40 && done_cnt < base + 1; c++) begin
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1 ready = 0;
    wait_done(base + 2, 40);
    chk("b2b_keeps", 64'({keep_log[0], keep_log[1], keep_log[2]}), 64'hFFFF80);
    chk("b2b_lasts", 64'({last_log[0], last_log[1], last_log[2]}), 64'b101);
    chk("b2b_beats", 64'(beat_cnt), 64'd3);
    // reset after beat 2 of a 5-beat packet
    clear_logs();
    send(40);
    for (int c = 0; c < 40 && beat_cnt < 2; c++) @(posedge clk);
    #2 rst = 0;
    #1 chk("midrst_ctl", 64'({rd_en, done, tvalid, tlast, tkeep, rd_addr}), 64'd0);
    chk("midrst_tdata", tdata, 64'd0);
    chk("midrst_beats", 64'(beat_cnt), 64'd2);
    base = done_cnt;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    repeat (3) @(posedge clk);
    #1 chk("midrst_no_done", 64'(done_cnt), 64'(base));
    seed = 64'h5555_AAAA_0F0F_F0F0;
    clear_logs();
    send(16);
    wait_done(base + 1, 40);
    chk("post_rst_addr0", 64'(addr_log[0]), 64'd0);
    chk("post_rst_beats", 64'(beat_cnt), 64'd2);
    send(8);
    wait_done(base + 2, 40);
    send(12);
    wait_done(base + 3, 40);
`ifdef FWD_PKT_COUNT_EN
    chk("pkt_count", 64'(pkt_count), 64'd3);
`endif
    chk("model_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
